// File: rtl/puc_pkg.sv
// Shared definitions for the PUC multicycle core: opcodes, FSM states, instruction fields.
package puc_pkg;

  localparam int INSTRUCTION_WIDTH = 32;

  localparam int OPCODE_MSB  = 28;
  localparam int OPCODE_LSB  = 24;
  localparam int ADDR1_MSB   = 23;
  localparam int ADDR1_LSB   = 16;
  localparam int ADDR2_MSB   = 15;
  localparam int ADDR2_LSB   = 8;
  localparam int ADDROUT_MSB = 7;
  localparam int ADDROUT_LSB = 0;

  localparam logic [4:0] OP_NOP        = 5'd0;
  localparam logic [4:0] OP_RESET      = 5'd1;
  localparam logic [4:0] OP_LOAD       = 5'd2;
  localparam logic [4:0] OP_ADD        = 5'd3;
  localparam logic [4:0] OP_INC        = 5'd4;
  localparam logic [4:0] OP_DECREMENT  = 5'd5;
  localparam logic [4:0] OP_LSHIFT     = 5'd6;
  localparam logic [4:0] OP_RSHIFT     = 5'd7;
  localparam logic [4:0] OP_LOADSWITCH = 5'd8;
  localparam logic [4:0] OP_JUMP       = 5'd9;
  localparam logic [4:0] OP_JUMPZERO   = 5'd10;
  localparam logic [4:0] OP_HALT       = 5'd11;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  function automatic logic is_reg_write(input logic [4:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_INC) ||
           (op == OP_DECREMENT) || (op == OP_LSHIFT) || (op == OP_RSHIFT) ||
           (op == OP_LOADSWITCH);
  endfunction

endpackage

// File: rtl/puc_alu.sv
// Combinational ALU for the PUC core; results wrap at REGISTER_WIDTH.
module puc_alu
  import puc_pkg::*;
#(
  parameter int REGISTER_WIDTH = 8
) (
  input  logic [4:0]                op,
  input  logic [REGISTER_WIDTH-1:0] op_a,
  input  logic [REGISTER_WIDTH-1:0] op_b,
  input  logic [7:0]                value,
  input  logic                      sw,
  output logic [REGISTER_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:        result = op_a + op_b;
      OP_INC:        result = op_a + REGISTER_WIDTH'(1);
      OP_DECREMENT:  result = op_a - REGISTER_WIDTH'(1);
      OP_LSHIFT:     result = op_a << 1;
      OP_RSHIFT:     result = op_a >> 1;
      OP_LOAD:       result = REGISTER_WIDTH'(value);
      OP_LOADSWITCH: result = REGISTER_WIDTH'(sw);
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/puc_cpu_multicycle.sv
// PUC multicycle core: FETCH/EXECUTE/WRITEBACK FSM, register file and pc.
// Optional PUC_PERF_COUNT_EN adds the retiredCount port.
module puc_cpu_multicycle
  import puc_pkg::*;
#(
  parameter int REGISTER_WIDTH      = 8,
  parameter int NUMBER_OF_REGISTERS = 8,
  parameter int PC_WIDTH            = 8
) (
  input  logic                         clock,
  input  logic                         isResetN,
  input  logic                         switch,
  output logic                         imemReq,
  output logic [PC_WIDTH-1:0]          imemAddr,
  input  logic                         imemValid,
  input  logic [INSTRUCTION_WIDTH-1:0] imemData,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [REGISTER_WIDTH-1:0]    register1Value,
  output logic                         halted
`ifdef PUC_PERF_COUNT_EN
  ,
  output logic [31:0]                  retiredCount
`endif
);

  localparam int IDX_W = $clog2(NUMBER_OF_REGISTERS);

  state_e                    state_q, state_d;
  logic                      started_q, started_d;
  logic [4:0]                op_q, op_d;
  logic [IDX_W-1:0]          a1_q, a1_d;
  logic [IDX_W-1:0]          out_q, out_d;
  logic [7:0]                val_q, val_d;
  logic [REGISTER_WIDTH-1:0] result_q, result_d;
  logic [PC_WIDTH-1:0]       npc_q, npc_d;
  logic [PC_WIDTH-1:0]       pc_q, pc_d;
  logic [REGISTER_WIDTH-1:0] regs_q [NUMBER_OF_REGISTERS];
  logic [REGISTER_WIDTH-1:0] regs_d [NUMBER_OF_REGISTERS];

  logic [REGISTER_WIDTH-1:0] rd_a, rd_b, alu_result;
  logic                      fetch_accept, in_wb, soft_rst, rst_any;
  logic                      unused_instr_bits;

  assign unused_instr_bits = ^{imemData[31:29],
                               imemData[ADDR1_MSB:ADDR1_LSB+IDX_W],
                               imemData[ADDROUT_MSB:ADDROUT_LSB+IDX_W]};

  // The RESET opcode behaves exactly like the external reset, applied at writeback.
  assign in_wb    = (state_q == ST_WRITEBACK);
  assign soft_rst = in_wb && (op_q == OP_RESET);
  assign rst_any  = !isResetN || soft_rst;

  assign fetch_accept = imemReq && imemValid;
  assign rd_a = regs_q[a1_q];
  assign rd_b = regs_q[val_q[IDX_W-1:0]];

  puc_alu #(.REGISTER_WIDTH(REGISTER_WIDTH)) u_alu (
    .op     (op_q),
    .op_a   (rd_a),
    .op_b   (rd_b),
    .value  (val_q),
    .sw     (switch),
    .result (alu_result)
  );

  always_ff @(posedge clock) begin
    if (rst_any) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (fetch_accept) state_d = ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = (op_q == OP_HALT) ? ST_HALT : ST_FETCH;
      default:      state_d = ST_HALT;
    endcase
  end

  // Request is held off for one cycle after reset so it never rises during reset.
  always_comb begin
    imemReq = (state_q == ST_FETCH) && started_q;
    halted  = (state_q == ST_HALT);
  end

  always_comb begin
    started_d = 1'b1;
    op_d      = op_q;
    a1_d      = a1_q;
    out_d     = out_q;
    val_d     = val_q;
    result_d  = result_q;
    npc_d     = npc_q;
    pc_d      = pc_q;
    regs_d    = regs_q;
    if (state_q == ST_FETCH && fetch_accept) begin
      op_d  = imemData[OPCODE_MSB:OPCODE_LSB];
      a1_d  = imemData[ADDR1_LSB +: IDX_W];
      out_d = imemData[ADDROUT_LSB +: IDX_W];
      val_d = imemData[ADDR2_MSB:ADDR2_LSB];
    end
    if (state_q == ST_EXECUTE) begin
      result_d = alu_result;
      case (op_q)
        OP_JUMP:     npc_d = PC_WIDTH'(val_q);
        OP_JUMPZERO: npc_d = (rd_a == '0) ? PC_WIDTH'(val_q) : pc_q + PC_WIDTH'(1);
        default:     npc_d = pc_q + PC_WIDTH'(1);
      endcase
    end
    if (in_wb && op_q != OP_HALT) begin
      pc_d = npc_q;
      if (is_reg_write(op_q) && out_q != '0) regs_d[out_q] = result_q;
    end
  end

  always_ff @(posedge clock) begin
    if (rst_any) begin
      started_q <= 1'b0;
      op_q      <= OP_NOP;
      a1_q      <= '0;
      out_q     <= '0;
      val_q     <= '0;
      result_q  <= '0;
      npc_q     <= '0;
      pc_q      <= '0;
      for (int i = 0; i < NUMBER_OF_REGISTERS; i++) regs_q[i] <= '0;
    end else begin
      started_q <= started_d;
      op_q      <= op_d;
      a1_q      <= a1_d;
      out_q     <= out_d;
      val_q     <= val_d;
      result_q  <= result_d;
      npc_q     <= npc_d;
      pc_q      <= pc_d;
      regs_q    <= regs_d;
    end
  end

  assign pc             = pc_q;
  assign imemAddr       = pc_q;
  assign register1Value = regs_q[1];

`ifdef PUC_PERF_COUNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (in_wb && op_q != OP_HALT) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (rst_any) retired_q <= '0;
    else         retired_q <= retired_d;
  end

  assign retiredCount = retired_q;
`endif

endmodule

// File: tb/tb_puc_cpu_multicycle.sv
// Directed, table-driven bench for puc_cpu_multicycle (optionally with PUC_PERF_COUNT_EN).
module tb_puc_cpu_multicycle;
  import puc_pkg::*;

  logic        clock = 1'b0;
  logic        isResetN;
  logic        switch;
  logic        imemReq;
  logic [7:0]  imemAddr;
  logic        imemValid;
  logic [31:0] imemData;
  logic [7:0]  pc;
  logic [7:0]  register1Value;
  logic        halted;
`ifdef PUC_PERF_COUNT_EN
  logic [31:0] retiredCount;
`endif

  puc_cpu_multicycle #(
    .REGISTER_WIDTH(8), .NUMBER_OF_REGISTERS(8), .PC_WIDTH(8)
  ) dut (
    .clock          (clock),
    .isResetN       (isResetN),
    .switch         (switch),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemValid      (imemValid),
    .imemData       (imemData),
    .pc             (pc),
    .register1Value (register1Value),
    .halted         (halted)
`ifdef PUC_PERF_COUNT_EN
    ,
    .retiredCount   (retiredCount)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic        sw;
    int          delay;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_r1;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs [0:21];

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [7:0] a1,
                                      input logic [7:0] val, input logic [7:0] aout);
    return {3'b000, op, a1, val, aout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for a fetch, hold off imemValid for 'delay' cycles, then run until the next FETCH.
  task automatic issue(input logic [31:0] instr, input int delay,
                       input logic [7:0] exp_addr, output int lat);
    int  waited = 0;
    bit  stable = 1'b1;
    lat = 0;
    while (imemReq !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (imemReq !== 1'b1) begin
      check("imem_req_timeout", {31'd0, imemReq}, 32'd1);
      return;
    end
    imemData = instr;
    for (int i = 0; i < delay; i++) begin
      if (imemAddr !== exp_addr || imemReq !== 1'b1) stable = 1'b0;
      @(negedge clock);
      lat++;
    end
    if (delay > 0) check("imem_addr_stable", {31'd0, stable}, 32'd1);
    check("imem_addr", {24'd0, imemAddr}, {24'd0, exp_addr});
    imemValid = 1'b1;
    @(negedge clock);
    lat++;
    imemValid = 1'b0;
    check("imem_req_low_in_execute", {31'd0, imemReq}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    lat += 2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  ok;

    vecs[0]  = '{enc(OP_LOAD,       8'h00, 8'hFE, 8'h01), 1'b0, 4, 8'h00, 8'hFE, 8'h01};
    vecs[1]  = '{enc(OP_INC,        8'h01, 8'h00, 8'h01), 1'b0, 0, 8'h01, 8'hFF, 8'h02};
    vecs[2]  = '{enc(OP_INC,        8'h01, 8'h00, 8'h01), 1'b0, 1, 8'h02, 8'h00, 8'h03};
    vecs[3]  = '{enc(OP_LOAD,       8'h00, 8'h00, 8'h02), 1'b0, 0, 8'h03, 8'h00, 8'h04};
    vecs[4]  = '{enc(OP_JUMPZERO,   8'h02, 8'h10, 8'h00), 1'b0, 2, 8'h04, 8'h00, 8'h10};
    vecs[5]  = '{enc(OP_LOAD,       8'h00, 8'h01, 8'h02), 1'b0, 0, 8'h10, 8'h00, 8'h11};
    vecs[6]  = '{enc(OP_JUMPZERO,   8'h02, 8'h20, 8'h00), 1'b0, 0, 8'h11, 8'h00, 8'h12};
    vecs[7]  = '{enc(OP_LOADSWITCH, 8'h00, 8'h00, 8'h01), 1'b1, 0, 8'h12, 8'h01, 8'h13};
    vecs[8]  = '{enc(OP_LOAD,       8'h00, 8'h55, 8'h00), 1'b0, 0, 8'h13, 8'h01, 8'h14};
    vecs[9]  = '{enc(OP_ADD,        8'h00, 8'h01, 8'h01), 1'b0, 0, 8'h14, 8'h01, 8'h15};
    vecs[10] = '{enc(OP_LOAD,       8'h00, 8'h81, 8'h03), 1'b0, 0, 8'h15, 8'h01, 8'h16};
    vecs[11] = '{enc(OP_ADD,        8'h03, 8'h03, 8'h01), 1'b0, 0, 8'h16, 8'h02, 8'h17};
    vecs[12] = '{enc(OP_DECREMENT,  8'h00, 8'h00, 8'h01), 1'b0, 0, 8'h17, 8'hFF, 8'h18};
    vecs[13] = '{enc(OP_RSHIFT,     8'h01, 8'h00, 8'h01), 1'b0, 0, 8'h18, 8'h7F, 8'h19};
    vecs[14] = '{enc(OP_LSHIFT,     8'h01, 8'h00, 8'h01), 1'b0, 0, 8'h19, 8'hFE, 8'h1A};
    vecs[15] = '{enc(OP_LOAD,       8'h00, 8'h33, 8'h09), 1'b0, 0, 8'h1A, 8'h33, 8'h1B};
    vecs[16] = '{enc(OP_NOP,        8'h00, 8'h00, 8'h01), 1'b0, 0, 8'h1B, 8'h33, 8'h1C};
    vecs[17] = '{enc(5'h1F,         8'h00, 8'h00, 8'h01), 1'b0, 0, 8'h1C, 8'h33, 8'h1D};
    vecs[18] = '{enc(OP_JUMP,       8'h00, 8'hFF, 8'h00), 1'b0, 0, 8'h1D, 8'h33, 8'hFF};
    vecs[19] = '{enc(OP_NOP,        8'h00, 8'h00, 8'h00), 1'b0, 0, 8'hFF, 8'h33, 8'h00};
    vecs[20] = '{enc(OP_LOADSWITCH, 8'h00, 8'hFF, 8'h01), 1'b0, 0, 8'h00, 8'h00, 8'h01};
    vecs[21] = '{enc(OP_INC,        8'h09, 8'h00, 8'h01), 1'b0, 0, 8'h01, 8'h01, 8'h02};

    isResetN  = 1'b0;
    switch    = 1'b0;
    imemValid = 1'b0;
    imemData  = '0;

    repeat (3) @(negedge clock);
    check("rst_pc",     {24'd0, pc},             32'd0);
    check("rst_r1",     {24'd0, register1Value}, 32'd0);
    check("rst_req",    {31'd0, imemReq},        32'd0);
    check("rst_halted", {31'd0, halted},         32'd0);
`ifdef PUC_PERF_COUNT_EN
    check("rst_retired", retiredCount, 32'd0);
`endif
    isResetN = 1'b1;

    for (int i = 0; i < 22; i++) begin
      switch = vecs[i].sw;
      issue(vecs[i].instr, vecs[i].delay, vecs[i].exp_addr, lat);
      check($sformatf("vec%0d_r1", i),      {24'd0, register1Value}, {24'd0, vecs[i].exp_r1});
      check($sformatf("vec%0d_pc", i),      {24'd0, pc},             {24'd0, vecs[i].exp_pc});
      check($sformatf("vec%0d_latency", i), lat,                     vecs[i].delay + 3);
      check($sformatf("vec%0d_halted", i),  {31'd0, halted},         32'd0);
    end

    // Reset asserted while a fetch is being accepted must win.
    @(negedge clock);
    imemData  = enc(OP_LOAD, 8'h00, 8'hAA, 8'h01);
    imemValid = 1'b1;
    isResetN  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("midfetch_rst%0d_pc", i),     {24'd0, pc},             32'd0);
      check($sformatf("midfetch_rst%0d_r1", i),     {24'd0, register1Value}, 32'd0);
      check($sformatf("midfetch_rst%0d_req", i),    {31'd0, imemReq},        32'd0);
      check($sformatf("midfetch_rst%0d_halted", i), {31'd0, halted},         32'd0);
    end
    imemValid = 1'b0;
    isResetN  = 1'b1;

    // RESET opcode clears pc and registers.
    issue(enc(OP_LOAD, 8'h00, 8'h5A, 8'h01), 0, 8'h00, lat);
    check("pre_softrst_r1", {24'd0, register1Value}, 32'h5A);
    issue(enc(OP_RESET, 8'h00, 8'h00, 8'h00), 0, 8'h01, lat);
    check("softrst_pc",  {24'd0, pc},             32'd0);
    check("softrst_r1",  {24'd0, register1Value}, 32'd0);
    check("softrst_req", {31'd0, imemReq},        32'd0);

    // Five retiring instructions, then HALT.
    issue(enc(OP_LOAD, 8'h00, 8'h11, 8'h01), 0, 8'h00, lat);
    issue(enc(OP_INC,  8'h01, 8'h00, 8'h01), 0, 8'h01, lat);
    issue(enc(OP_INC,  8'h01, 8'h00, 8'h01), 1, 8'h02, lat);
    issue(enc(OP_NOP,  8'h00, 8'h00, 8'h00), 0, 8'h03, lat);
    issue(enc(OP_JUMP, 8'h00, 8'h40, 8'h00), 0, 8'h04, lat);
    check("seq_r1", {24'd0, register1Value}, 32'h13);
    check("seq_pc", {24'd0, pc},             32'h40);
    issue(enc(OP_HALT, 8'h00, 8'h00, 8'h00), 0, 8'h40, lat);
    check("halt_halted", {31'd0, halted},  32'd1);
    check("halt_req",    {31'd0, imemReq}, 32'd0);
    check("halt_pc",     {24'd0, pc},      32'h40);

    ok = 1'b1;
    imemValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (imemReq !== 1'b0 || halted !== 1'b1 || pc !== 8'h40 || register1Value !== 8'h13)
        ok = 1'b0;
    end
    imemValid = 1'b0;
    check("halt_persists", {31'd0, ok}, 32'd1);
`ifdef PUC_PERF_COUNT_EN
    check("retired_count", retiredCount, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
